// File: rtl/processor_8085_multi.sv
// Multi-cycle core for a register-only 8085 subset: FETCH, DECODE, EXECUTE, with HLT parking in HALT.
// Instructions come from a 256x16 ROM. Only A and the Z/CY flags leave the block.

module processor_8085_multi_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       is_hlt,
    output logic [1:0] cur_state
);
    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] DECODE  = 2'd1;
    localparam logic [1:0] EXECUTE = 2'd2;
    localparam logic [1:0] HALT    = 2'd3;

    logic [1:0] state = FETCH;
    logic [1:0] next_state;

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   next_state = DECODE;
            DECODE:  next_state = EXECUTE;
            EXECUTE: next_state = is_hlt ? HALT : FETCH;
            default: next_state = HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= next_state;
        end
    end

    assign cur_state = state;
endmodule

module processor_8085_multi_rf (
    input  logic       clk,
    input  logic       we,
    input  logic [2:0] waddr,
    input  logic [7:0] wdata,
    input  logic [2:0] raddr,
    output logic [7:0] rdata
);
    // B,C,D,E,H,L; deliberately not touched by reset
    logic [7:0] reg_file [0:5];

    always_ff @(posedge clk) begin
        if (we && (waddr < 3'd6)) begin
            reg_file[waddr] <= wdata;
        end
    end

    assign rdata = (raddr < 3'd6) ? reg_file[raddr] : 8'h00;
endmodule

module processor_8085_multi (
    input  logic       clk,
    input  logic       reset,
    output logic       z,
    output logic       cy,
    output logic [7:0] ACC
);
    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] DECODE  = 2'd1;
    localparam logic [1:0] EXECUTE = 2'd2;

    localparam logic [2:0] REG_M = 3'd6;
    localparam logic [2:0] REG_A = 3'd7;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_ANA = 3'd4;
    localparam logic [2:0] ALU_XRA = 3'd5;
    localparam logic [2:0] ALU_ORA = 3'd6;
    localparam logic [2:0] ALU_CMP = 3'd7;

    logic [15:0] imem [0:255];

    // Declaration values match the reset values so the core runs without a reset pulse
    logic [7:0]  pc      = 8'h00;
    logic [15:0] IRout   = 16'h0000;
    logic [7:0]  Accout  = 8'h00;
    logic        z_flag  = 1'b0;
    logic        cy_flag = 1'b0;
    logic [7:0]  operand = 8'h00;

    logic [1:0]  state;
    logic [7:0]  aluout;
    logic [8:0]  alu_wide;
    logic        Accwrite;
    logic        rf_we;
    logic [7:0]  rf_rdata;

    logic [7:0]  opcode;
    logic [7:0]  imm;
    logic [2:0]  dst;
    logic [2:0]  src;
    logic [2:0]  alu_op;
    logic [2:0]  rd_sel;
    logic [7:0]  rd_val;
    logic        is_hlt;
    logic        is_mov;
    logic        is_mvi;
    logic        is_inr;
    logic        is_dcr;
    logic        alu_ok;
    logic        is_alu_r;
    logic        is_alu_i;
    logic        is_alu;
    logic        writes_dst;
    logic        jump_taken;

    initial begin
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    end

    assign opcode = IRout[15:8];
    assign imm    = IRout[7:0];
    assign dst    = opcode[5:3];
    assign src    = opcode[2:0];
    assign alu_op = opcode[5:3];

    // Any form touching M, plus ADC/SBB, decodes to nothing and so behaves as NOP
    assign is_hlt     = (opcode == 8'h76);
    assign is_mov     = (opcode[7:6] == 2'b01) && !is_hlt && (dst != REG_M) && (src != REG_M);
    assign is_mvi     = (opcode[7:6] == 2'b00) && (src == 3'b110) && (dst != REG_M);
    assign is_inr     = (opcode[7:6] == 2'b00) && (src == 3'b100) && (dst != REG_M);
    assign is_dcr     = (opcode[7:6] == 2'b00) && (src == 3'b101) && (dst != REG_M);
    assign alu_ok     = (alu_op != 3'd1) && (alu_op != 3'd3);
    assign is_alu_r   = (opcode[7:6] == 2'b10) && (src != REG_M) && alu_ok;
    assign is_alu_i   = (opcode[7:6] == 2'b11) && (src == 3'b110) && alu_ok;
    assign is_alu     = is_alu_r || is_alu_i;
    assign writes_dst = is_mov || is_mvi || is_inr || is_dcr;

    always_comb begin
        jump_taken = 1'b0;
        case (opcode)
            8'hC3:   jump_taken = 1'b1;
            8'hC2:   jump_taken = !z_flag;
            8'hCA:   jump_taken = z_flag;
            8'hD2:   jump_taken = !cy_flag;
            8'hDA:   jump_taken = cy_flag;
            default: jump_taken = 1'b0;
        endcase
    end

    assign rd_sel = (is_inr || is_dcr) ? dst : src;
    assign rd_val = (rd_sel == REG_A) ? Accout : rf_rdata;

    // Bit 8 is the carry for ADD and the borrow for SUB/CMP; logic ops leave it clear
    always_comb begin
        alu_wide = {1'b0, operand};
        if (is_inr) begin
            alu_wide = {1'b0, operand} + 9'd1;
        end else if (is_dcr) begin
            alu_wide = {1'b0, operand} - 9'd1;
        end else if (is_alu) begin
            case (alu_op)
                ALU_ADD:          alu_wide = {1'b0, Accout} + {1'b0, operand};
                ALU_SUB, ALU_CMP: alu_wide = {1'b0, Accout} - {1'b0, operand};
                ALU_ANA:          alu_wide = {1'b0, Accout & operand};
                ALU_XRA:          alu_wide = {1'b0, Accout ^ operand};
                ALU_ORA:          alu_wide = {1'b0, Accout | operand};
                default:          alu_wide = {1'b0, operand};
            endcase
        end
    end

    assign aluout = alu_wide[7:0];

    assign Accwrite = (state == EXECUTE) &&
                      ((writes_dst && (dst == REG_A)) || (is_alu && (alu_op != ALU_CMP)));
    assign rf_we    = (state == EXECUTE) && writes_dst && (dst != REG_A);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= 8'h00;
            IRout   <= 16'h0000;
            Accout  <= 8'h00;
            z_flag  <= 1'b0;
            cy_flag <= 1'b0;
            operand <= 8'h00;
        end else begin
            case (state)
                FETCH: begin
                    IRout <= imem[pc];
                    pc    <= pc + 8'd1;
                end
                DECODE: begin
                    operand <= (is_mvi || is_alu_i) ? imm : rd_val;
                end
                EXECUTE: begin
                    if (Accwrite) begin
                        Accout <= aluout;
                    end
                    if (is_alu) begin
                        z_flag  <= (aluout == 8'h00);
                        cy_flag <= alu_wide[8];
                    end else if (is_inr || is_dcr) begin
                        z_flag <= (aluout == 8'h00);
                    end
                    if (jump_taken) begin
                        pc <= imm;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    processor_8085_multi_ctrl contr (
        .clk       (clk),
        .reset     (reset),
        .is_hlt    (is_hlt),
        .cur_state (state)
    );

    processor_8085_multi_rf rf1_1 (
        .clk   (clk),
        .we    (rf_we),
        .waddr (dst),
        .wdata (aluout),
        .raddr (rd_sel),
        .rdata (rf_rdata)
    );

    assign ACC = Accout;
    assign z   = z_flag;
    assign cy  = cy_flag;
endmodule

// File: tb/tb_processor_8085_multi.sv
// Bench for processor_8085_multi: a directed program whose retirements are scored against
// hand-computed {pc, A, Z, CY, B} tuples, followed by HALT hold and reset re-run checks.

module tb_processor_8085_multi;
    logic       clk   = 1'b0;
    logic       reset = 1'b0;
    logic       z;
    logic       cy;
    logic [7:0] acc;

    int checks = 0;
    int passed = 0;

    logic [25:0] exp_q [$];
    logic [25:0] mon_e;
    logic [1:0]  prev_state = 2'd0;
    int          cyc_since  = 0;
    int          retired    = 0;
    int          stray_aw   = 0;

    processor_8085_multi dut (
        .clk   (clk),
        .reset (reset),
        .z     (z),
        .cy    (cy),
        .ACC   (acc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, got, want);
        end
    endtask

    task automatic push_exp(input logic [7:0] p, input logic [7:0] a, input logic zz,
                            input logic cc, input logic [7:0] b);
        exp_q.push_back({p, a, zz, cc, b});
    endtask

    task automatic put(input logic [7:0] addr, input logic [15:0] word);
        dut.imem[addr] = word;
    endtask

    task automatic load_program();
        for (int i = 0; i < 256; i++) dut.imem[i] = 16'h3E77;
        put(8'h00, 16'h7800);  // MOV A,B
        put(8'h01, 16'h8100);  // ADD C
        put(8'h02, 16'h3EFF);  // MVI A,FF
        put(8'h03, 16'hC601);  // ADI 01
        put(8'h04, 16'h3E02);  // MVI A,02
        put(8'h05, 16'h9200);  // SUB D
        put(8'h06, 16'hA400);  // ANA H
        put(8'h07, 16'h3E04);  // MVI A,04
        put(8'h08, 16'hBB00);  // CMP E
        put(8'h09, 16'hC200);  // JNZ 00
        put(8'h0A, 16'hCA10);  // JZ 10
        put(8'h10, 16'h06AA);  // MVI B,AA
        put(8'h11, 16'h0400);  // INR B
        put(8'h12, 16'h0D00);  // DCR C
        put(8'h13, 16'hB500);  // ORA L
        put(8'h14, 16'hAF00);  // XRA A
        put(8'h15, 16'hD604);  // SUI 04
        put(8'h16, 16'hDA20);  // JC 20
        put(8'h20, 16'hD220);  // JNC 20
        put(8'h21, 16'h8800);  // ADC B
        put(8'h22, 16'h7700);  // MOV M,A
        put(8'h23, 16'h7600);  // HLT
        for (int i = 0; i < 6; i++) dut.rf1_1.reg_file[i] = 8'(i + 1);
    endtask

    // Monitor: one retirement per EXECUTE->FETCH transition
    always @(negedge clk) begin
        if (dut.Accwrite && (dut.contr.state != 2'd2)) stray_aw++;
        cyc_since++;
        if (dut.contr.state == 2'd0) begin
            if ((prev_state == 2'd2) && (exp_q.size() > 0)) begin
                retired++;
                mon_e = exp_q.pop_front();
                check($sformatf("retire%0d", retired),
                      {6'd0, dut.pc, acc, z, cy, dut.rf1_1.reg_file[0]}, {6'd0, mon_e});
                check($sformatf("cycles%0d", retired), cyc_since, 3);
            end
            cyc_since = 0;
        end
        prev_state = dut.contr.state;
    end

    initial begin
        #1;
        load_program();
        check("pwr_pc", dut.pc, 0);
        check("pwr_acc", acc, 0);
        check("pwr_flags", {z, cy}, 0);
        check("pwr_state", dut.contr.state, 0);
        check("pwr_ir", dut.IRout, 0);

        push_exp(8'h01, 8'h01, 1'b0, 1'b0, 8'h01);  // MOV A,B
        push_exp(8'h02, 8'h03, 1'b0, 1'b0, 8'h01);  // ADD C
        push_exp(8'h03, 8'hFF, 1'b0, 1'b0, 8'h01);  // MVI A,FF
        push_exp(8'h04, 8'h00, 1'b1, 1'b1, 8'h01);  // ADI 01
        push_exp(8'h05, 8'h02, 1'b1, 1'b1, 8'h01);  // MVI keeps flags
        push_exp(8'h06, 8'hFF, 1'b0, 1'b1, 8'h01);  // 02-03
        push_exp(8'h07, 8'h05, 1'b0, 1'b0, 8'h01);  // FF&05
        push_exp(8'h08, 8'h04, 1'b0, 1'b0, 8'h01);  // MVI A,04
        push_exp(8'h09, 8'h04, 1'b1, 1'b0, 8'h01);  // CMP E (E=4)
        push_exp(8'h0A, 8'h04, 1'b1, 1'b0, 8'h01);  // JNZ not taken
        push_exp(8'h10, 8'h04, 1'b1, 1'b0, 8'h01);  // JZ taken
        push_exp(8'h11, 8'h04, 1'b1, 1'b0, 8'hAA);  // MVI B,AA
        push_exp(8'h12, 8'h04, 1'b0, 1'b0, 8'hAB);  // INR B
        push_exp(8'h13, 8'h04, 1'b0, 1'b0, 8'hAB);  // DCR C -> 01
        push_exp(8'h14, 8'h06, 1'b0, 1'b0, 8'hAB);  // 04|06
        push_exp(8'h15, 8'h00, 1'b1, 1'b0, 8'hAB);  // XRA A
        push_exp(8'h16, 8'hFC, 1'b0, 1'b1, 8'hAB);  // 00-04
        push_exp(8'h20, 8'hFC, 1'b0, 1'b1, 8'hAB);  // JC taken
        push_exp(8'h21, 8'hFC, 1'b0, 1'b1, 8'hAB);  // JNC not taken
        push_exp(8'h22, 8'hFC, 1'b0, 1'b1, 8'hAB);  // ADC is NOP
        push_exp(8'h23, 8'hFC, 1'b0, 1'b1, 8'hAB);  // MOV M,A is NOP

        for (int i = 0; i < 400 && dut.contr.state != 2'd3; i++) @(negedge clk);
        check("reach_halt", dut.contr.state, 3);
        check("drain_main", exp_q.size(), 0);
        check("dcr_c", dut.rf1_1.reg_file[1], 8'h01);

        repeat (12) @(negedge clk);
        check("halt_state", dut.contr.state, 3);
        check("halt_pc", dut.pc, 8'h24);
        check("halt_acc", {acc, z, cy}, {8'hFC, 1'b0, 1'b1});

        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rst_state", dut.contr.state, 0);
        check("rst_pc", dut.pc, 0);
        check("rst_acc", acc, 0);
        check("rst_flags", {z, cy}, 0);
        check("rst_ir", dut.IRout, 0);
        check("rst_keeps_rf", dut.rf1_1.reg_file[0], 8'hAB);

        // Re-run sees the registers left by the first pass: B=AB, C=01
        push_exp(8'h01, 8'hAB, 1'b0, 1'b0, 8'hAB);
        push_exp(8'h02, 8'hAC, 1'b0, 1'b0, 8'hAB);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_rerun", exp_q.size(), 0);
        check("accwrite_outside_exec", stray_aw, 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
